uart_tx_serializer: RTL and testbench

//   Transmit half of the RFID/RSA UART link. Serializes one parallel word per request

---
 rtl/uart_tx_serializer_if.sv | 43 ++++
 rtl/uart_tx_serializer.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer_if
//   Bundles the oversample tick, the byte request handshake and the serial
//   line of the UART transmitter.
//   Signals:
//     s_tick       1-cycle oversample tick at 16x baud (from the baud timer)
//     tx_start     request to send tx_data (honoured only while idle)
//     tx_data      word to send, captured when the request is accepted
//     tx           serial line, idle high
//     tx_busy      high while a frame is in flight
//     tx_done_tick 1-cycle pulse when the stop bit completes
//   Modports:
//     master  byte source / tick source (drives requests, observes status)
//     slave   the serializer itself
// ---------------------------------------------------------------------------
interface uart_tx_serializer_if #(
    parameter int DBIT = 8
);
    logic            s_tick;
    logic            tx_start;
    logic [DBIT-1:0] tx_data;
    logic            tx;
    logic            tx_busy;
    logic            tx_done_tick;

    modport master (
        output s_tick,
        output tx_start,
        output tx_data,
        input  tx,
        input  tx_busy,
        input  tx_done_tick
    );

    modport slave (
        input  s_tick,
        input  tx_start,
        input  tx_data,
        output tx,
        output tx_busy,
        output tx_done_tick
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//   Transmit half of the RFID/RSA UART link. Sends one DBIT-wide word per
//   accepted request as: start bit (0), data LSB first, optional parity bit,
//   stop bit(s) (1). Every bit lasts 16 s_tick events; the stop bit lasts
//   SB_TICK events. tx_done_tick lets the result streamer issue the next word
//   in the very cycle the line returns to idle, giving gapless back-to-back
//   frames.
//   Ports:
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset; abandons any frame in flight
//     bus      uart_tx_serializer_if.slave (s_tick, tx_start, tx_data in;
//              tx, tx_busy, tx_done_tick out, all straight from flops)
//   Parameters:
//     DBIT        data bits per frame (1..16)
//     SB_TICK     stop length in s_tick events (16 = 1 stop, 32 = 2 stop)
//     PARITY_EN   1 appends a parity bit after the data
//     PARITY_ODD  1 selects odd parity, 0 even
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    uart_tx_serializer_if.slave   bus
);

    // A single data bit still needs a one-bit counter to keep the port legal.
    localparam int            NW        = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [4:0]    BIT_LAST  = 5'd15;
    localparam logic [4:0]    STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    logic [4:0]      s_cnt;
    logic [NW-1:0]   n_cnt;
    logic [DBIT-1:0] b_reg;
    logic [DBIT-1:0] b_shift;
    logic            par_reg;
    logic            tx_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            bit_end;
    logic            stop_end;

    // Parity bit value that makes the total count of ones even (or odd).
    function automatic logic parity_of(input logic [DBIT-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    assign b_shift  = b_reg >> 1;
    assign bit_end  = bus.s_tick && (s_cnt == BIT_LAST);
    assign stop_end = bus.s_tick && (s_cnt == STOP_LAST);

    // The line value for the next bit is loaded on the same edge that
    // changes state, so tx is a plain flop and moves only at bit boundaries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            s_cnt    <= '0;
            n_cnt    <= '0;
            b_reg    <= '0;
            par_reg  <= 1'b0;
            tx_reg   <= 1'b1;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    tx_reg <= 1'b1;
                    // A tick arriving together with the request is not
                    // counted: the start bit always begins at s_cnt = 0.
                    if (bus.tx_start) begin
                        b_reg    <= bus.tx_data;
                        par_reg  <= parity_of(bus.tx_data);
                        s_cnt    <= '0;
                        tx_reg   <= 1'b0;
                        busy_reg <= 1'b1;
                        state    <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        s_cnt  <= '0;
                        n_cnt  <= '0;
                        tx_reg <= b_reg[0];
                        state  <= DATA;
                    end else if (bus.s_tick) begin
                        s_cnt <= s_cnt + 5'd1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        b_reg <= b_shift;
                        s_cnt <= '0;
                        if (n_cnt == N_LAST) begin
                            if (PARITY_EN != 0) begin
                                tx_reg <= par_reg;
                                state  <= PARITY;
                            end else begin
                                tx_reg <= 1'b1;
                                state  <= STOP;
                            end
                        end else begin
                            n_cnt  <= n_cnt + 1'b1;
                            tx_reg <= b_shift[0];
                        end
                    end else if (bus.s_tick) begin
                        s_cnt <= s_cnt + 5'd1;
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        s_cnt  <= '0;
                        tx_reg <= 1'b1;
                        state  <= STOP;
                    end else if (bus.s_tick) begin
                        s_cnt <= s_cnt + 5'd1;
                    end
                end

                STOP: begin
                    tx_reg <= 1'b1;
                    // Busy drops together with the done pulse, so a request
                    // held high is accepted in the done cycle itself.
                    if (stop_end) begin
                        s_cnt    <= '0;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                        state    <= IDLE;
                    end else if (bus.s_tick) begin
                        s_cnt <= s_cnt + 5'd1;
                    end
                end

                default: begin
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx           = tx_reg;
    assign bus.tx_busy      = busy_reg;
    assign bus.tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//   Four serializer configurations share one stimulus stream:
//     cfg[0] 8 data, no parity, 1 stop    cfg[1] 8 data, even parity, 1 stop
//     cfg[2] 8 data, odd parity, 1 stop   cfg[3] 8 data, no parity, 2 stop
//   A reference model works in whole frames measured in s_tick events: on
//   acceptance it pushes the expected per-tick line pattern into a FIFO and
//   counts down the ticks left in the frame. A separate monitor records the
//   line at every counted tick and pops/compares when tx_done_tick appears.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int NDUT = 4;
    localparam int DBIT = 8;
    localparam int QD   = 16;

    function automatic int cfg_pe(input int k);
        return (k == 1 || k == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_odd(input int k);
        return (k == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_sb(input int k);
        return (k == 3) ? 32 : 16;
    endfunction
    function automatic int frame_ticks(input int k);
        return 16 * (1 + DBIT + cfg_pe(k)) + cfg_sb(k);
    endfunction

    // Expected line value at every counted tick of one frame.
    task automatic build_frame(input int k, input logic [7:0] d,
                               output logic [255:0] seq, output int len);
        int  ones;
        logic pbit;
        seq  = '0;
        len  = 0;
        ones = 0;
        for (int i = 0; i < 16; i++) begin seq[len] = 1'b0; len++; end
        for (int j = 0; j < DBIT; j++) begin
            if (d[j]) ones++;
            for (int i = 0; i < 16; i++) begin seq[len] = d[j]; len++; end
        end
        if (cfg_pe(k) != 0) begin
            pbit = (cfg_odd(k) != 0) ? (ones % 2 == 0) : (ones % 2 == 1);
            for (int i = 0; i < 16; i++) begin seq[len] = pbit; len++; end
        end
        for (int i = 0; i < cfg_sb(k); i++) begin seq[len] = 1'b1; len++; end
    endtask

    logic            clk = 1'b0;
    logic            reset_n;
    logic            s_tick = 1'b0;
    logic            tx_start = 1'b0;
    logic [DBIT-1:0] tx_data = '0;
    logic [NDUT-1:0] tx_w, busy_w, done_w;

    int tick_mode = 0;   // 0: tick every 4 clocks, 1: random gaps
    int lat_chk   = 0;   // cfg[0] frame must span exactly 640 busy cycles
    int to_cnt    = 0;   // bounded waits that expired (written by stimulus)

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NDUT; g++) begin : cfg
            uart_tx_serializer_if #(.DBIT(DBIT)) bus ();
            assign bus.s_tick   = s_tick;
            assign bus.tx_start = tx_start;
            assign bus.tx_data  = tx_data;
            assign tx_w[g]      = bus.tx;
            assign busy_w[g]    = bus.tx_busy;
            assign done_w[g]    = bus.tx_done_tick;
            uart_tx_serializer #(
                .DBIT      (DBIT),
                .SB_TICK   ((g == 3) ? 32 : 16),
                .PARITY_EN ((g == 1 || g == 2) ? 1 : 0),
                .PARITY_ODD((g == 2) ? 1 : 0)
            ) dut (
                .clk    (clk),
                .reset_n(reset_n),
                .bus    (bus)
            );
        end
    endgenerate

    // ---------------- reference model (pushes expectations) ----------------
    int            rem      [NDUT];
    logic          exp_done [NDUT];
    int            wr       [NDUT];
    logic [255:0]  fifo_seq [NDUT][QD];
    int            fifo_len [NDUT][QD];
    logic [7:0]    fifo_dat [NDUT][QD];

    initial begin
        logic [255:0] s;
        int           l;
        for (int k = 0; k < NDUT; k++) begin
            rem[k] = 0; exp_done[k] = 1'b0; wr[k] = 0;
        end
        forever begin
            @(posedge clk or negedge reset_n);
            for (int k = 0; k < NDUT; k++) begin
                if (!reset_n) begin
                    rem[k] = 0; exp_done[k] = 1'b0; wr[k] = 0;
                end else begin
                    exp_done[k] = 1'b0;
                    if (rem[k] == 0) begin
                        if (tx_start) begin
                            build_frame(k, tx_data, s, l);
                            fifo_seq[k][wr[k] % QD] = s;
                            fifo_len[k][wr[k] % QD] = l;
                            fifo_dat[k][wr[k] % QD] = tx_data;
                            wr[k]++;
                            rem[k] = frame_ticks(k);
                        end
                    end else if (s_tick) begin
                        rem[k]--;
                        if (rem[k] == 0) exp_done[k] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int           checks = 0;
    int           errors = 0;
    int           rd     [NDUT];
    int           cnt    [NDUT];
    int           runlen [NDUT];
    logic [255:0] cap    [NDUT];

    initial begin
        int to_seen;
        int idx, nbad, first;
        to_seen = 0;
        for (int k = 0; k < NDUT; k++) begin
            rd[k] = 0; cnt[k] = 0; runlen[k] = 0; cap[k] = '0;
        end
        forever begin
            @(negedge clk or negedge reset_n);
            if (!reset_n) begin
                #1;
                for (int k = 0; k < NDUT; k++) begin
                    checks++;
                    if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL reset_outputs cfg%0d: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                                 k, tx_w[k], busy_w[k], done_w[k]);
                    end
                    rd[k] = 0; cnt[k] = 0; runlen[k] = 0;
                end
            end else begin
                for (int k = 0; k < NDUT; k++) begin
                    checks++;
                    if (busy_w[k] !== (rem[k] != 0)) begin
                        errors++;
                        $display("FAIL busy cfg%0d t=%0t: got %b, required %b", k, $time, busy_w[k], rem[k] != 0);
                    end
                    checks++;
                    if (done_w[k] !== exp_done[k]) begin
                        errors++;
                        $display("FAIL done_tick cfg%0d t=%0t: got %b, required %b", k, $time, done_w[k], exp_done[k]);
                    end
                    if (rem[k] == 0) begin
                        checks++;
                        if (tx_w[k] !== 1'b1) begin
                            errors++;
                            $display("FAIL idle_line cfg%0d t=%0t: tx=%b, required 1", k, $time, tx_w[k]);
                        end
                    end
                    if (busy_w[k] === 1'b1) runlen[k]++;
                    if (rem[k] != 0 && s_tick) begin
                        if (cnt[k] < 256) cap[k][cnt[k]] = tx_w[k];
                        cnt[k]++;
                    end
                    if (done_w[k] === 1'b1) begin
                        checks++;
                        if (rd[k] == wr[k]) begin
                            errors++;
                            $display("FAIL unexpected_frame cfg%0d t=%0t: done pulse with no accepted word, required none", k, $time);
                        end else begin
                            idx = rd[k] % QD;
                            checks++;
                            if (cnt[k] != fifo_len[k][idx]) begin
                                errors++;
                                $display("FAIL frame_len cfg%0d data=%02h: %0d ticks, required %0d",
                                         k, fifo_dat[k][idx], cnt[k], fifo_len[k][idx]);
                            end
                            nbad = 0; first = -1;
                            for (int i = 0; i < fifo_len[k][idx] && i < 256; i++) begin
                                if (cap[k][i] !== fifo_seq[k][idx][i]) begin
                                    nbad++;
                                    if (first < 0) first = i;
                                end
                            end
                            checks++;
                            if (nbad != 0) begin
                                errors++;
                                $display("FAIL frame_bits cfg%0d data=%02h: %0d wrong ticks (first at tick %0d), required 0",
                                         k, fifo_dat[k][idx], nbad, first);
                            end
                            rd[k]++;
                        end
                        if (k == 0 && lat_chk != 0) begin
                            checks++;
                            if (runlen[0] != 640) begin
                                errors++;
                                $display("FAIL frame_clocks cfg0: busy %0d clk, required 640", runlen[0]);
                            end
                        end
                        cnt[k] = 0; runlen[k] = 0; cap[k] = '0;
                    end
                end
            end
            if (to_cnt != to_seen) begin
                checks++;
                errors++;
                $display("FAIL wait_timeout: %0d expired waits, required 0", to_cnt - to_seen);
                to_seen = to_cnt;
            end
        end
    end

    // ---------------- tick source ----------------
    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_mode == 0) begin
                s_tick = (tcnt == 3);
                tcnt   = (tcnt + 1) % 4;
            end else begin
                s_tick = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int maxcyc);
        int n, quiet;
        n = 0; quiet = 0;
        while (quiet < 3 && n < maxcyc) begin
            step();
            n++;
            if (busy_w == '0) quiet++; else quiet = 0;
        end
        if (quiet < 3) to_cnt++;
    endtask

    // Issue a one-cycle request in a cycle that carries a tick, so that the
    // coincident tick must be ignored and the frame timing is exact.
    task automatic send_aligned(input logic [7:0] d);
        int n;
        n = 0;
        while (s_tick !== 1'b1 && n < 8) begin step(); n++; end
        if (s_tick !== 1'b1) to_cnt++;
        tx_start = 1'b1;
        tx_data  = d;
        step();
        tx_start = 1'b0;
        tx_data  = $urandom();
    endtask

    initial begin
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (10) step();

        // Regular ticks, aligned starts: exact frame timing and parity.
        tick_mode = 0;
        lat_chk   = 1;
        send_aligned(8'hA5);
        wait_idle(2000);
        send_aligned(8'h07);
        wait_idle(2000);
        lat_chk = 0;

        // Requests with 0xFF while busy must be ignored.
        send_aligned(8'h3C);
        repeat (5) begin
            repeat ($urandom_range(40, 100)) step();
            tx_start = 1'b1;
            tx_data  = 8'hFF;
            step();
            tx_start = 1'b0;
        end
        wait_idle(2000);

        // Back-to-back with tx_start held high.
        tx_start = 1'b1;
        tx_data  = 8'h55;
        step();
        tx_data  = 8'hAA;
        repeat (800) step();
        tx_start = 1'b0;
        wait_idle(2000);

        // Randomly gapped ticks with random requests and data.
        tick_mode = 1;
        repeat (3000) begin
            tx_start = ($urandom_range(0, 99) == 0);
            tx_data  = $urandom();
            step();
        end
        tx_start = 1'b0;
        wait_idle(3000);

        // Asynchronous reset in the middle of the data bits.
        tick_mode = 0;
        send_aligned(8'hC3);
        repeat (300) step();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (20) step();
        lat_chk = 1;
        send_aligned(8'h96);
        wait_idle(2000);
        lat_chk = 0;

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
